// File: rtl/link_out_arbiter.sv
// Round-robin arbiter and MSB-first byte serializer for one outbound link.
// Pops the winning FIFO on grant and streams its packet with put/free.
module link_out_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PKT_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PKT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_pop,
  input  logic                         free_outbound,
  output logic                         put_outbound,
  output logic [7:0]                   payload_outbound,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int BYTES = PKT_WIDTH / 8;
  localparam int CW    = $clog2(BYTES + 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t                 r_state;
  logic [IDW-1:0]         r_last;
  logic [IDW-1:0]         r_gid;
  logic [CW-1:0]          r_cnt;
  logic [PKT_WIDTH-1:0]   r_shift;
  logic                   r_put;
  logic [7:0]             r_payload;
  logic                   r_busy;

  logic                   w_found;
  logic [IDW-1:0]         w_win;
  logic [IDW:0]           w_sum;
  logic [PKT_WIDTH-1:0]   w_pkt;
  logic                   w_grant;
  logic [NUM_REQ-1:0]     w_pop;

  // Scan last+1, last+2, ... with wrap; first valid index wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NUM_REQ))
        w_sum = w_sum - (IDW+1)'(NUM_REQ);
      if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDW'(i))
        w_pkt = req_data[i*PKT_WIDTH +: PKT_WIDTH];
    end
  end

  assign w_grant = reset_n & (r_state == S_IDLE)
                 & free_outbound & w_found;

  always_comb begin
    w_pop = '0;
    if (w_grant)
      w_pop[w_win] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_last    <= IDW'(NUM_REQ - 1);
      r_gid     <= '0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_put     <= 1'b0;
      r_payload <= 8'h00;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_last    <= w_win;
            r_gid     <= w_win;
            r_shift   <= w_pkt << 8;
            r_put     <= 1'b1;
            r_payload <= w_pkt[PKT_WIDTH-1 -: 8];
            r_cnt     <= CW'(1);
            r_busy    <= 1'b1;
            r_state   <= S_SEND;
          end else begin
            r_put     <= 1'b0;
            r_payload <= 8'h00;
          end
        end
        S_SEND: begin
          // r_cnt counts bytes already on the link
          if (r_cnt == CW'(BYTES)) begin
            r_put     <= 1'b0;
            r_payload <= 8'h00;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_payload <= r_shift[PKT_WIDTH-1 -: 8];
            r_shift   <= r_shift << 8;
            r_cnt     <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign req_pop          = w_pop;
  assign put_outbound     = r_put;
  assign payload_outbound = r_payload;
  assign grant_id         = r_gid;
  assign busy             = r_busy;

endmodule

// File: tb/tb_link_out_arbiter.sv
// Directed bench for link_out_arbiter: arbitration order, serialization,
// stalls, mid-packet behaviour and reset during a send.
module tb_link_out_arbiter;

  logic         clock;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_pop;
  logic         free_outbound;
  logic         put_outbound;
  logic [7:0]   payload_outbound;
  logic [1:0]   grant_id;
  logic         busy;

  logic [31:0]  pkt [4];
  int           n_chk;
  int           n_fail;

  link_out_arbiter #(
    .NUM_REQ   (4),
    .PKT_WIDTH (32)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_pop          (req_pop),
    .free_outbound    (free_outbound),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] p,
                                         input int b);
    return p[31-8*b -: 8];
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] p;
    int          e;
    n_chk  = 0;
    n_fail = 0;
    pkt[0] = 32'h0A1B2C3D;
    pkt[1] = 32'h11223344;
    pkt[2] = 32'hDEADBEEF;
    pkt[3] = 32'hC0FFEE99;
    req_data = {pkt[3], pkt[2], pkt[1], pkt[0]};

    // reset with every requester valid
    reset_n       = 1'b0;
    req_valid     = 4'b1111;
    free_outbound = 1'b1;
    #1;
    chk("rst_pop_pre", 32'(req_pop), 32'h0);
    step();
    chk("rst_put", 32'(put_outbound), 32'h0);
    chk("rst_pay", 32'(payload_outbound), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_pop", 32'(req_pop), 32'h0);
    step();
    chk("rst_put2", 32'(put_outbound), 32'h0);
    chk("rst_pop2", 32'(req_pop), 32'h0);

    // single requester 2
    req_valid = 4'b0100;
    reset_n   = 1'b1;
    #1;
    chk("r2_pop", 32'(req_pop), 32'h4);
    step();
    req_valid = 4'b0000;
    #1;
    chk("r2_gid", 32'(grant_id), 32'h2);
    chk("r2_busy", 32'(busy), 32'h1);
    for (int b = 0; b < 4; b++) begin
      chk("r2_put", 32'(put_outbound), 32'h1);
      chk("r2_pay", 32'(payload_outbound), 32'(byte_of(32'hDEADBEEF, b)));
      chk("r2_popx", 32'(req_pop), 32'h0);
      step();
    end
    chk("r2_put_end", 32'(put_outbound), 32'h0);
    chk("r2_pay_end", 32'(payload_outbound), 32'h0);
    chk("r2_busy_end", 32'(busy), 32'h0);
    step();
    chk("r2_idle", 32'(put_outbound), 32'h0);

    // all valid: strict rotation from requester 0
    do_reset();
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      p = pkt[e];
      chk("rr_pop", 32'(req_pop), 32'(4'b0001 << e));
      step();
      chk("rr_gid", 32'(grant_id), 32'(e));
      for (int b = 0; b < 4; b++) begin
        chk("rr_put", 32'(put_outbound), 32'h1);
        chk("rr_pay", 32'(payload_outbound), 32'(byte_of(p, b)));
        chk("rr_popx", 32'(req_pop), 32'h0);
        step();
      end
      chk("rr_gap", 32'(put_outbound), 32'h0);
      if (k == 4) begin
        req_valid = 4'b0000;
        #1;
        chk("rr_stop", 32'(req_pop), 32'h0);
      end
    end

    // stall on free=0 with requester 1 waiting
    req_valid     = 4'b0010;
    free_outbound = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("st_pop", 32'(req_pop), 32'h0);
      step();
      chk("st_put", 32'(put_outbound), 32'h0);
    end
    free_outbound = 1'b1;
    #1;
    chk("st_grant", 32'(req_pop), 32'h2);
    step();
    req_valid = 4'b0000;
    chk("st_gid", 32'(grant_id), 32'h1);
    chk("st_pay", 32'(payload_outbound), 32'h11);
    repeat (4) step();
    chk("st_done", 32'(put_outbound), 32'h0);

    // free drops and requester 3 arrives mid-send of requester 0
    req_valid = 4'b0001;
    #1;
    chk("ms_pop0", 32'(req_pop), 32'h1);
    step();
    req_valid     = 4'b1000;
    free_outbound = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) begin
      chk("ms_put", 32'(put_outbound), 32'h1);
      chk("ms_pay", 32'(payload_outbound), 32'(byte_of(pkt[0], b)));
      chk("ms_popx", 32'(req_pop), 32'h0);
      step();
    end
    chk("ms_idle_put", 32'(put_outbound), 32'h0);
    chk("ms_idle_pop", 32'(req_pop), 32'h0);
    step();
    chk("ms_idle_put2", 32'(put_outbound), 32'h0);
    free_outbound = 1'b1;
    #1;
    chk("ms_pop3", 32'(req_pop), 32'h8);
    step();
    req_valid = 4'b0000;
    chk("ms_gid3", 32'(grant_id), 32'h3);
    chk("ms_pay3", 32'(payload_outbound), 32'hC0);
    repeat (4) step();
    chk("ms_done", 32'(put_outbound), 32'h0);

    // reset while byte 2 of requester 1 is on the link
    req_valid = 4'b0010;
    #1;
    chk("rs_pop1", 32'(req_pop), 32'h2);
    step();
    req_valid = 4'b0000;
    step();
    step();
    chk("rs_byte2", 32'(payload_outbound), 32'h33);
    reset_n   = 1'b0;
    req_valid = 4'b0101;
    #1;
    chk("rs_pop_rst", 32'(req_pop), 32'h0);
    step();
    chk("rs_put", 32'(put_outbound), 32'h0);
    chk("rs_busy", 32'(busy), 32'h0);
    chk("rs_gid", 32'(grant_id), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rs_ptr", 32'(req_pop), 32'h1);
    step();
    req_valid = 4'b0000;
    chk("rs_gid0", 32'(grant_id), 32'h0);
    chk("rs_pay0", 32'(payload_outbound), 32'h0A);
    repeat (4) step();
    chk("rs_done", 32'(put_outbound), 32'h0);
    step();
    chk("rs_nosend", 32'(put_outbound), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
